// File: rtl/row_cache_fill_engine.sv
// rtl/row_cache_fill_engine.sv - row cache miss fill engine: victim write-back then row fetch
// Optional STATS_EN macro enables saturating fetch/write-back counters.
module row_cache_fill_engine #(
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int CIDWIDTH  = 5,
  parameter int BL        = 8,
  parameter int TRCD      = 14,
  parameter int TRP       = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 WB,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic [ADDRWIDTH-1:0] VictimRowId,
  input  logic [CIDWIDTH-1:0]  cRowId,
  output logic                 MemOK,
  output logic                 busy,
  output logic                 mem_act,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 mem_pre,
  output logic [ADDRWIDTH-1:0] mem_row,
  output logic [COLWIDTH-1:0]  mem_col,
  output logic [CIDWIDTH-1:0]  mem_slot,
  output logic [15:0]          stat_fetch,
  output logic [15:0]          stat_wb
);

  localparam int COLS = 1 << COLWIDTH;
  localparam int NB   = COLS / BL;
  localparam int HALF = BL / 2;
  localparam int XFC  = NB * HALF;
  localparam int MAXA = (TRCD > TRP) ? TRCD : TRP;
  localparam int MAXC = (MAXA > XFC) ? MAXA : XFC;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam int SUBW = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACT  = 3'd1;
  localparam logic [2:0] RCD  = 3'd2;
  localparam logic [2:0] XFER = 3'd3;
  localparam logic [2:0] PRE  = 3'd4;
  localparam logic [2:0] RP   = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  logic [2:0]           state;
  logic [CNTW-1:0]      cnt;
  logic [SUBW-1:0]      sub;
  logic                 phase_wb;
  logic                 guard;
  logic [ADDRWIDTH-1:0] row_l;

  assign busy = (state != IDLE);

  // Strobes are registered on the transition so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sub      <= '0;
      phase_wb <= 1'b0;
      guard    <= 1'b0;
      row_l    <= '0;
      MemOK    <= 1'b0;
      mem_act  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_pre  <= 1'b0;
      mem_row  <= '0;
      mem_col  <= '0;
      mem_slot <= '0;
    end else begin
      mem_act <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_pre <= 1'b0;
      MemOK   <= 1'b0;
      case (state)
        IDLE: begin
          guard <= 1'b0;
          if (hold && !guard) begin
            row_l    <= RowId;
            mem_slot <= cRowId;
            phase_wb <= WB;
            mem_row  <= WB ? VictimRowId : RowId;
            mem_act  <= 1'b1;
            state    <= ACT;
          end
        end
        ACT: begin
          cnt   <= CNTW'(TRCD - 1);
          state <= RCD;
        end
        RCD: begin
          if (cnt == '0) begin
            state   <= XFER;
            cnt     <= CNTW'(XFC - 1);
            sub     <= '0;
            mem_col <= '0;
            mem_wr  <= phase_wb;
            mem_rd  <= !phase_wb;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XFER: begin
          if (sub == SUBW'(HALF - 1)) begin
            sub     <= '0;
            mem_col <= mem_col + COLWIDTH'(BL);
          end else begin
            sub <= sub + 1'b1;
          end
          if (cnt == '0) begin
            state   <= PRE;
            mem_pre <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            if (sub == SUBW'(HALF - 1)) begin
              mem_wr <= phase_wb;
              mem_rd <= !phase_wb;
            end
          end
        end
        PRE: begin
          cnt   <= CNTW'(TRP - 1);
          state <= RP;
        end
        RP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (phase_wb) begin
            phase_wb <= 1'b0;
            mem_row  <= row_l;
            mem_act  <= 1'b1;
            state    <= ACT;
          end else begin
            MemOK <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          guard <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetch <= '0;
      stat_wb    <= '0;
    end else begin
      if (state == DONE && stat_fetch != 16'hFFFF) stat_fetch <= stat_fetch + 16'd1;
      if (state == PRE && phase_wb && stat_wb != 16'hFFFF) stat_wb <= stat_wb + 16'd1;
    end
  end
`else
  assign stat_fetch = 16'd0;
  assign stat_wb    = 16'd0;
`endif

endmodule

// File: tb/tb_row_cache_fill_engine.sv
// tb/tb_row_cache_fill_engine.sv - scoreboard bench for row_cache_fill_engine
module tb_row_cache_fill_engine;

  localparam int AW = 17, CW = 4, SW = 5, BL = 8, TRCD = 3, TRP = 2;
  localparam int NB = (1 << CW) / BL;
  localparam int XF = NB * BL / 2;
  localparam int PL = 2 + TRCD + XF + TRP;
  localparam int K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_OK = 5;

  logic clk = 1'b0, rst = 1'b1, hold = 1'b0, WB = 1'b0;
  logic [AW-1:0] RowId = '0, VictimRowId = '0;
  logic [SW-1:0] cRowId = '0;
  logic MemOK, busy, mem_act, mem_rd, mem_wr, mem_pre;
  logic [AW-1:0] mem_row;
  logic [CW-1:0] mem_col;
  logic [SW-1:0] mem_slot;
  logic [15:0] stat_fetch, stat_wb;

  row_cache_fill_engine #(.ADDRWIDTH(AW), .COLWIDTH(CW), .CIDWIDTH(SW), .BL(BL),
                          .TRCD(TRCD), .TRP(TRP)) dut (
    .clk(clk), .rst(rst), .hold(hold), .WB(WB), .RowId(RowId), .VictimRowId(VictimRowId),
    .cRowId(cRowId), .MemOK(MemOK), .busy(busy), .mem_act(mem_act), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_pre(mem_pre), .mem_row(mem_row), .mem_col(mem_col),
    .mem_slot(mem_slot), .stat_fetch(stat_fetch), .stat_wb(stat_wb)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int cyc; int row; int col; int slot;} evt_t;
  evt_t q[$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int n_fetch = 0, n_wb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_evt(input int kind, input int c, input int row, input int col, input int slot);
    evt_t e;
    e.kind = kind; e.cyc = c; e.row = row; e.col = col; e.slot = slot;
    q.push_back(e);
  endtask

  task automatic push_phase(input int b, input bit wbph, input int row, input int slot);
    push_evt(K_ACT, b + 1, row, 0, slot);
    for (int i = 0; i < NB; i++)
      push_evt(wbph ? K_WR : K_RD, b + 2 + TRCD + i * (BL / 2), row, i * BL, slot);
    push_evt(K_PRE, b + 2 + TRCD + XF, row, 0, slot);
  endtask

  // Every strobe cycle must match the head of the expected-event queue.
  always @(negedge clk) begin
    int ns, code;
    evt_t e;
    if (!rst) begin
      ns = int'(mem_act) + int'(mem_rd) + int'(mem_wr) + int'(mem_pre) + int'(MemOK);
      if (ns > 1) chk("strobe_excl", ns, 1);
      if (ns != 0) begin
        code = mem_act ? K_ACT : mem_rd ? K_RD : mem_wr ? K_WR : mem_pre ? K_PRE : K_OK;
        if (q.size() == 0) begin
          chk("unexpected_strobe", code, 0);
        end else begin
          e = q.pop_front();
          chk("evt_kind", code, e.kind);
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_slot", mem_slot, e.slot);
          if (e.kind != K_OK) chk("evt_row", mem_row, e.row);
          if (e.kind == K_RD || e.kind == K_WR) chk("evt_col", mem_col, e.col);
        end
      end
    end
  end

  task automatic do_fill(input bit wb, input int vic, input int row, input int slot,
                         input int drop_at, input bit extra);
    int b, k;
    b = cyc;
    if (wb) begin
      push_phase(b, 1'b1, vic, slot);
      b += PL;
    end
    push_phase(b, 1'b0, row, slot);
    push_evt(K_OK, b + PL + 1, 0, 0, slot);
    WB = wb; VictimRowId = AW'(vic); RowId = AW'(row); cRowId = SW'(slot); hold = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        RowId = AW'($urandom); VictimRowId = AW'($urandom); cRowId = SW'($urandom); WB = ~wb;
      end
      if (k == drop_at) hold = 1'b0;
    end while (!MemOK && k < 200);
    if (!MemOK) chk("fill_timeout", 0, 1);
    chk("busy_at_ok", busy, 1);
    if (extra) repeat (2) @(negedge clk);
    hold = 1'b0; WB = 1'b0;
    n_fetch++;
    if (wb) n_wb++;
    repeat (3) @(negedge clk);
    chk("idle_after_fill", busy, 0);
  endtask

  initial begin
    int b;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_memok", MemOK, 0);
    chk("rst_strobes", {mem_act, mem_rd, mem_wr, mem_pre}, 0);
    chk("rst_row", mem_row, 0);
    chk("rst_col", mem_col, 0);
    chk("rst_slot", mem_slot, 0);
    chk("rst_stats", {stat_fetch, stat_wb}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_hold", busy, 0);

    do_fill(1'b0, 0, 150, 5, 0, 1'b0);
    chk("slot_hold", mem_slot, 5);
    do_fill(1'b1, 7, 150, 3, 0, 1'b0);
    do_fill(1'b0, 0, 300, 12, 3, 1'b0);
    do_fill(1'b0, 0, 1000, 31, 0, 1'b1);
    do_fill(1'b1, 131071, 0, 0, 0, 1'b0);
    chk("queue_drained", q.size(), 0);
`ifdef STATS_EN
    chk("stat_fetch", stat_fetch, n_fetch);
    chk("stat_wb", stat_wb, n_wb);
`else
    chk("stat_fetch", stat_fetch, 0);
    chk("stat_wb", stat_wb, 0);
`endif

    b = cyc;
    push_evt(K_ACT, b + 1, 150, 0, 9);
    push_evt(K_RD, b + 2 + TRCD, 150, 0, 9);
    WB = 1'b0; RowId = AW'(150); cRowId = SW'(9); hold = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1; hold = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_strobes", {mem_act, mem_rd, mem_wr, mem_pre, MemOK}, 0);
    n_fetch = 0; n_wb = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle", busy, 0);
    chk("midrst_queue", q.size(), 0);
    chk("midrst_stats", {stat_fetch, stat_wb}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
